// File: rtl/psg_fade_ctrl.sv
// PSG attribute write-port arbiter: host writes pass straight through, and a fade engine steps
// the volume of masked voices toward a target. Define PSG_FADE_ABORT_EN to add the fade_abort input.
module psg_fade_ctrl #(
   parameter int unsigned NUM_VOICES = 16,
   parameter int unsigned DIV_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            host_addr,
   input  logic [7:0]            host_wrdata,
   input  logic                  host_write,
   input  logic                  next_sample,
   input  logic                  fade_start,
   input  logic [5:0]            fade_target,
   input  logic [NUM_VOICES-1:0] fade_mask,
   input  logic [DIV_W-1:0]      fade_div,
`ifdef PSG_FADE_ABORT_EN
   input  logic                  fade_abort,
`endif
   output logic                  fade_busy,
   output logic                  fade_done,
   output logic [5:0]            attr_addr,
   output logic [7:0]            attr_wrdata,
   output logic                  attr_write
);

   typedef enum logic [2:0] {StIdle, StWait, StScan, StIssue, StDone} state_e;

   localparam logic [3:0] LastIdx = 4'(NUM_VOICES - 1);

   state_e                state_q, state_d;
   logic [5:0]            tgt_q, tgt_d;
   logic [NUM_VOICES-1:0] mask_q, mask_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [DIV_W-1:0]      cnt_q, cnt_d;
   logic                  changed_q, changed_d;
   logic [3:0]            idx_q, idx_d;
   logic [7:0]            pend_q, pend_d;
   logic [7:0]            shadow_q [NUM_VOICES];
   logic [7:0]            shadow_d [NUM_VOICES];
   logic [5:0]            attr_addr_q, attr_addr_d;
   logic [7:0]            attr_wrdata_q, attr_wrdata_d;
   logic                  attr_write_q, attr_write_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  abort;
   logic [3:0]            host_voice;
   logic                  host_vol;
   logic                  host_hits_idx;
   logic [7:0]            cur;
   logic [5:0]            cur_vol;
   logic [5:0]            step_vol;
   logic                  needs_step;

`ifdef PSG_FADE_ABORT_EN
   assign abort = fade_abort;
`else
   assign abort = 1'b0;
`endif

   assign host_voice    = host_addr[5:2];
   assign host_vol      = host_write && (host_addr[1:0] == 2'b10) &&
                          (32'(host_voice) < NUM_VOICES);
   assign host_hits_idx = host_vol && (host_voice == idx_q);

   assign cur        = shadow_q[idx_q];
   assign cur_vol    = cur[5:0];
   // Only used when cur_vol != tgt_q, so the step can never wrap past 0 or 63.
   assign step_vol   = (cur_vol < tgt_q) ? (cur_vol + 6'd1) : (cur_vol - 6'd1);
   assign needs_step = mask_q[idx_q] && (cur_vol != tgt_q);

   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      mask_d        = mask_q;
      div_d         = div_q;
      cnt_d         = cnt_q;
      changed_d     = changed_q;
      idx_d         = idx_q;
      pend_d        = pend_q;
      attr_addr_d   = attr_addr_q;
      attr_wrdata_d = attr_wrdata_q;
      attr_write_d  = 1'b0;
      busy_d        = busy_q;
      done_d        = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         shadow_d[v] = shadow_q[v];
      end

      if (host_write) begin
         attr_addr_d   = host_addr;
         attr_wrdata_d = host_wrdata;
         attr_write_d  = 1'b1;
      end
      if (host_vol) begin
         shadow_d[host_voice] = host_wrdata;
      end

      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         busy_d  = 1'b0;
      end else if (fade_start) begin
         tgt_d     = fade_target;
         mask_d    = fade_mask;
         div_d     = fade_div;
         cnt_d     = '0;
         changed_d = 1'b0;
         busy_d    = 1'b1;
         state_d   = StWait;
      end else begin
         unique case (state_q)
            StIdle: ;
            StWait: begin
               if (next_sample) begin
                  if (cnt_q == div_q) begin
                     cnt_d     = '0;
                     changed_d = 1'b0;
                     idx_d     = 4'd0;
                     state_d   = StScan;
                  end else begin
                     cnt_d = cnt_q + DIV_W'(1);
                  end
               end
            end
            StScan: begin
               if (host_hits_idx) begin
                  // Host is rewriting this voice now; re-examine it next cycle.
                  state_d = StScan;
               end else if (needs_step) begin
                  pend_d    = {cur[7:6], step_vol};
                  changed_d = 1'b1;
                  state_d   = StIssue;
               end else if (idx_q == LastIdx) begin
                  if (changed_q) begin
                     state_d = StWait;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
            StIssue: begin
               if (host_hits_idx) begin
                  // Host value supersedes the pending step; recompute from it.
                  state_d = StScan;
               end else if (!host_write) begin
                  attr_addr_d     = {idx_q, 2'b10};
                  attr_wrdata_d   = pend_q;
                  attr_write_d    = 1'b1;
                  shadow_d[idx_q] = pend_q;
                  if (idx_q == LastIdx) begin
                     state_d = StWait;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = StScan;
                  end
               end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         tgt_q         <= '0;
         mask_q        <= '0;
         div_q         <= '0;
         cnt_q         <= '0;
         changed_q     <= 1'b0;
         idx_q         <= '0;
         pend_q        <= '0;
         attr_addr_q   <= '0;
         attr_wrdata_q <= '0;
         attr_write_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            shadow_q[v] <= '0;
         end
      end else begin
         state_q       <= state_d;
         tgt_q         <= tgt_d;
         mask_q        <= mask_d;
         div_q         <= div_d;
         cnt_q         <= cnt_d;
         changed_q     <= changed_d;
         idx_q         <= idx_d;
         pend_q        <= pend_d;
         attr_addr_q   <= attr_addr_d;
         attr_wrdata_q <= attr_wrdata_d;
         attr_write_q  <= attr_write_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         for (int v = 0; v < NUM_VOICES; v++) begin
            shadow_q[v] <= shadow_d[v];
         end
      end
   end

   assign attr_addr   = attr_addr_q;
   assign attr_wrdata = attr_wrdata_q;
   assign attr_write  = attr_write_q;
   assign fade_busy   = busy_q;
   assign fade_done   = done_q;

endmodule

// File: tb/tb_psg_fade_ctrl.sv
// Scoreboard bench for psg_fade_ctrl: stimulus pushes expected attribute writes and fade_done
// events; a negedge monitor pops and compares whenever the DUT presents them.
module tb_psg_fade_ctrl;

   localparam int unsigned NV = 16;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [5:0]    host_addr = '0;
   logic [7:0]    host_wrdata = '0;
   logic          host_write = 1'b0;
   logic          next_sample = 1'b0;
   logic          fade_start = 1'b0;
   logic [5:0]    fade_target = '0;
   logic [NV-1:0] fade_mask = '0;
   logic [DW-1:0] fade_div = '0;
   logic          fade_busy;
   logic          fade_done;
   logic [5:0]    attr_addr;
   logic [7:0]    attr_wrdata;
   logic          attr_write;

   psg_fade_ctrl #(
      .NUM_VOICES(NV),
      .DIV_W     (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .host_addr  (host_addr),
      .host_wrdata(host_wrdata),
      .host_write (host_write),
      .next_sample(next_sample),
      .fade_start (fade_start),
      .fade_target(fade_target),
      .fade_mask  (fade_mask),
      .fade_div   (fade_div),
`ifdef PSG_FADE_ABORT_EN
      .fade_abort (1'b0),
`endif
      .fade_busy  (fade_busy),
      .fade_done  (fade_done),
      .attr_addr  (attr_addr),
      .attr_wrdata(attr_wrdata),
      .attr_write (attr_write)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          done_seen = 0;
   int          done_exp = 0;
   logic [13:0] exp_q[$];

   logic [5:0] coll_addr [8] = '{6'h00, 6'h01, 6'h05, 6'h09, 6'h0D, 6'h11, 6'h0E, 6'h15};
   logic [7:0] coll_data [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h80, 8'h17};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [13:0] e;
      if (attr_write) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     attr_addr, attr_wrdata);
         end else begin
            e = exp_q.pop_front();
            check("attr_write", {18'd0, attr_addr, attr_wrdata}, {18'd0, e});
         end
      end
      if (fade_done) begin
         done_seen++;
         checks++;
         if (done_exp == 0) begin
            errors++;
            $display("FAIL unexpected_done: got fade_done=1, expected 0");
         end else begin
            done_exp--;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic host_wr(input logic [5:0] a, input logic [7:0] d);
      host_addr   = a;
      host_wrdata = d;
      host_write  = 1'b1;
      exp_q.push_back({a, d});
      cyc(1);
      host_write = 1'b0;
   endtask

   task automatic start(input logic [5:0] t, input logic [NV-1:0] m, input logic [DW-1:0] dv);
      fade_target = t;
      fade_mask   = m;
      fade_div    = dv;
      fade_start  = 1'b1;
      cyc(1);
      fade_start = 1'b0;
      check("busy_after_start", fade_busy, 1);
   endtask

   task automatic tick();
      next_sample = 1'b1;
      cyc(1);
      next_sample = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_seen;
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (done_seen != d0) begin
            got = 1'b1;
            break;
         end
         cyc(1);
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: got no fade_done within 200 cycles, expected a pulse", name);
      end else begin
         check({name, "_busy_cleared"}, fade_busy, 0);
      end
   endtask

   initial begin
      // Reset state
      cyc(3);
      check("rst_attr_addr", attr_addr, 0);
      check("rst_attr_wrdata", attr_wrdata, 0);
      check("rst_attr_write", attr_write, 0);
      check("rst_fade_busy", fade_busy, 0);
      check("rst_fade_done", fade_done, 0);
      rst = 1'b0;
      cyc(2);

      // Host pass-through, voice 1 shadow = 0xC8
      host_wr(6'h06, 8'hC8);
      cyc(2);

      // Voice 0 ramps 3 -> 5 with R/L preserved, one step per tick
      host_wr(6'h02, 8'hC3);
      start(6'd5, 16'h0001, 8'd0);
      exp_q.push_back({6'h02, 8'hC4});
      tick();
      cyc(30);
      check("v0_busy_mid", fade_busy, 1);
      exp_q.push_back({6'h02, 8'hC5});
      tick();
      cyc(30);
      done_exp++;
      tick();
      wait_done("v0_fade");

      // Voice 2 already at target: no writes, done after first pass
      host_wr(6'h0A, 8'h3F);
      start(6'h3F, 16'h0004, 8'd0);
      done_exp++;
      tick();
      wait_done("v2_at_target");

      // Empty mask
      start(6'h10, 16'h0000, 8'd0);
      done_exp++;
      tick();
      wait_done("empty_mask");

      // Voice 3: host overwrites the volume byte while engine step is pending
      host_wr(6'h0E, 8'h8A);
      start(6'd4, 16'h0008, 8'd0);
      next_sample = 1'b1;
      for (int i = 0; i < 8; i++) begin
         host_addr   = coll_addr[i];
         host_wrdata = coll_data[i];
         host_write  = 1'b1;
         exp_q.push_back({coll_addr[i], coll_data[i]});
         cyc(1);
         next_sample = 1'b0;
      end
      host_write = 1'b0;
      exp_q.push_back({6'h0E, 8'h81});
      cyc(40);
      for (int s = 2; s <= 4; s++) begin
         exp_q.push_back({6'h0E, 8'h80 | 8'(s)});
         tick();
         cyc(30);
      end
      done_exp++;
      tick();
      wait_done("v3_collision");

      // Voice 4: ten back-to-back host writes stall the engine step
      host_wr(6'h12, 8'h45);
      start(6'd3, 16'h0010, 8'd0);
      next_sample = 1'b1;
      for (int i = 0; i < 10; i++) begin
         host_addr   = 6'(i * 4 + 1);
         host_wrdata = 8'(8'hA0 + i);
         host_write  = 1'b1;
         exp_q.push_back({6'(i * 4 + 1), 8'(8'hA0 + i)});
         cyc(1);
         next_sample = 1'b0;
      end
      host_write = 1'b0;
      exp_q.push_back({6'h12, 8'h44});
      cyc(40);
      exp_q.push_back({6'h12, 8'h43});
      tick();
      cyc(30);
      done_exp++;
      tick();
      wait_done("v4_stall");

      // Voice 1 with divider 2, restart mid-fade, then reset mid-pass
      start(6'h0A, 16'h0002, 8'd2);
      tick();
      cyc(3);
      tick();
      cyc(3);
      exp_q.push_back({6'h06, 8'hC9});
      tick();
      cyc(30);
      start(6'd7, 16'h0002, 8'd0);
      exp_q.push_back({6'h06, 8'hC8});
      tick();
      cyc(30);
      check("restart_busy", fade_busy, 1);
      next_sample = 1'b1;
      cyc(1);
      next_sample = 1'b0;
      rst = 1'b1;
      cyc(1);
      check("midrst_attr_addr", attr_addr, 0);
      check("midrst_attr_wrdata", attr_wrdata, 0);
      check("midrst_attr_write", attr_write, 0);
      check("midrst_fade_busy", fade_busy, 0);
      check("midrst_fade_done", fade_done, 0);
      rst = 1'b0;
      cyc(2);
      tick();
      cyc(30);
      tick();
      cyc(30);
      check("post_rst_busy", fade_busy, 0);

      check("exp_queue_drained", exp_q.size(), 0);
      check("done_all_seen", done_exp, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
